fpf_decoder_12_pipe: RTL

//  Receiver-side decoder for the 12-TSV forbidden-pattern-free (FPF) Fibonacci link.
//  - Captures a 12-bit TSV word and checks it for forbidden patterns (101 / 010).
//  - Decodes it to a 9-bit data value using Fibonacci weights, in a 2-stage registered pipeline.
//  - Valid/ready handshake at both ends; sits between the TSV bundle and the core-side consumer.

---
 rtl/fpf_decoder_12_pipe_if.sv | 35 +++
 rtl/fpf_decoder_12_pipe.sv | 114 +++++++++++
 2 files changed

// File: rtl/fpf_decoder_12_pipe_if.sv
// Handshake/data bundle between the TSV receiver, the FPF decoder and the core-side consumer.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the decoder is the slave side.
//
// Signals:
//   tsv_in/in_valid/in_ready      received TSV word and its handshake
//   data_out/fp_err/out_valid/out_ready  decoded value, forbidden-pattern flag and handshake
//   err_clr/err_count             error counter clear and value (counter optional in the decoder)
interface fpf_decoder_12_pipe_if #(
    parameter int NTSV = 12,
    parameter int DW   = 9,
    parameter int CW   = 16
);
    logic [NTSV-1:0] tsv_in;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   data_out;
    logic            fp_err;
    logic            out_valid;
    logic            out_ready;
    logic            err_clr;
    logic [CW-1:0]   err_count;

    // Producer/consumer side (drives inputs of the decoder)
    modport master (
        output tsv_in, in_valid, out_ready, err_clr,
        input  in_ready, data_out, fp_err, out_valid, err_count
    );

    // Decoder side
    modport slave (
        input  tsv_in, in_valid, out_ready, err_clr,
        output in_ready, data_out, fp_err, out_valid, err_count
    );
endinterface

// File: rtl/fpf_decoder_12_pipe.sv
// Decodes a 12-bit forbidden-pattern-free Fibonacci TSV word to a 9-bit value and flags 101/010 patterns.
// Latency: 2 registered stages; a word presented in cycle 0 is on data_out in cycle 2.
// Backpressure: whole pipe advances only when output is empty or taken; in_ready = !out_valid || out_ready.
//
// Ports: clock, rst_n (synchronous, active low), bus (fpf_decoder_12_pipe_if.slave).
// Optional: define FPF_ERR_CNT_EN to build the saturating forbidden-pattern error counter;
// without it err_count reads 0 and err_clr is ignored.
module fpf_decoder_12_pipe #(
    parameter int NTSV = 12,
    parameter int DW   = 9,
    parameter int CW   = 16
) (
    input  logic                 clock,
    input  logic                 rst_n,
    fpf_decoder_12_pipe_if.slave bus
);

    // Fibonacci weight of TSV bit i; the table only makes sense for a 12-bit word.
    function automatic logic [DW-1:0] fib_w(input int i);
        case (i)
            0:       fib_w = DW'(1);
            1:       fib_w = DW'(1);
            2:       fib_w = DW'(2);
            3:       fib_w = DW'(3);
            4:       fib_w = DW'(5);
            5:       fib_w = DW'(8);
            6:       fib_w = DW'(13);
            7:       fib_w = DW'(21);
            8:       fib_w = DW'(34);
            9:       fib_w = DW'(55);
            10:      fib_w = DW'(89);
            default: fib_w = DW'(144);
        endcase
    endfunction

    logic          adv;
    logic [DW-1:0] lo_nxt;
    logic [DW-1:0] hi_nxt;
    logic          fp_nxt;

    logic          s1_v;
    logic [DW-1:0] s1_lo;
    logic [DW-1:0] s1_hi;
    logic          s1_fp;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Split the weighted sum into two halves so stage 2 only needs one adder.
    always_comb begin
        lo_nxt = '0;
        hi_nxt = '0;
        fp_nxt = 1'b0;
        for (int i = 0; i < NTSV / 2; i++) begin
            if (bus.tsv_in[i]) lo_nxt = lo_nxt + fib_w(i);
        end
        for (int i = NTSV / 2; i < NTSV; i++) begin
            if (bus.tsv_in[i]) hi_nxt = hi_nxt + fib_w(i);
        end
        // Every 3-bit window including the top one (bits 11..9).
        for (int j = 0; j <= NTSV - 3; j++) begin
            if (bus.tsv_in[j +: 3] == 3'b101 || bus.tsv_in[j +: 3] == 3'b010) fp_nxt = 1'b1;
        end
    end

    // Stage 1: partial sums and pattern flag. A bubble (no accept) loads s1_v = 0.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_lo <= '0;
            s1_hi <= '0;
            s1_fp <= 1'b0;
        end else if (adv) begin
            s1_v  <= bus.in_valid;
            s1_lo <= lo_nxt;
            s1_hi <= hi_nxt;
            s1_fp <= fp_nxt;
        end
    end

    // Stage 2: final sum. Max 376 fits in DW bits, so no overflow handling.
    // data_out is delivered even when fp_err is set; the consumer decides what to drop.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.fp_err    <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= s1_v;
            bus.data_out  <= s1_lo + s1_hi;
            bus.fp_err    <= s1_fp;
        end
    end

`ifdef FPF_ERR_CNT_EN
    logic [CW-1:0] err_cnt_q;

    // Counts delivered (transferred) bad words; clear beats a same-cycle increment.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            err_cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.fp_err && (err_cnt_q != {CW{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = {CW{1'b0}};
`endif

endmodule
